// File: rtl/greater_than_pkg.sv
// greater_than_pkg: shared types and limits for the 2-bit magnitude comparator.
// The optional build macro GREATER_THAN_SIGNED_EN is consumed by greater_than_core.
package greater_than_pkg;

  // 2-bit operand as assembled from the individual input bits
  typedef logic [1:0] operand_t;

  // One-hot compare result; exactly one field is set for a valid compare
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_flags_t;

  // Deepest pipeline the top level accepts
  localparam int MAX_PIPE_STAGES = 4;

endpackage

// File: rtl/greater_than_core.sv
// greater_than_core: purely combinational 2-bit compare leaf.
// Build option: define GREATER_THAN_SIGNED_EN to treat operands as two's
// complement (-2..1); otherwise they are unsigned (0..3). Only the gt
// equation changes between the two builds.
module greater_than_core
  import greater_than_pkg::*;
(
  input  operand_t   i_a,
  input  operand_t   i_b,
  output cmp_flags_t o_flags
);

  logic w_gt;
  logic w_eq;

  // Derive gt from the sign-appropriate equation, then eq, and lt as "neither"
  always_comb begin
    w_gt = 1'b0;
    w_eq = 1'b0;
`ifdef GREATER_THAN_SIGNED_EN
    // MSB is the sign bit, so a set MSB on B (negative) makes A the larger one
    w_gt = (~i_a[1] & i_b[1]) | (~(i_a[1] ^ i_b[1]) & i_a[0] & ~i_b[0]);
`else
    w_gt = (i_a[1] & ~i_b[1]) | (~(i_a[1] ^ i_b[1]) & i_a[0] & ~i_b[0]);
`endif
    w_eq = (i_a == i_b);
  end

  assign o_flags = '{gt: w_gt, eq: w_eq, lt: ~w_gt & ~w_eq};

endmodule

// File: rtl/greater_than.sv
// greater_than: registered 2-bit comparator with a fixed-depth valid pipeline.
// PIPE_STAGES (1..MAX_PIPE_STAGES) registers sit between the operand sample
// and the outputs. Build option GREATER_THAN_SIGNED_EN selects a signed
// compare inside greater_than_core; ports and timing are unaffected.
module greater_than
  import greater_than_pkg::*;
#(
  parameter int PIPE_STAGES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic a1,
  input  logic a0,
  input  logic b1,
  input  logic b0,
  output logic y,
  output logic eq,
  output logic lt,
  output logic out_valid
);

  // Reject unsupported depths while elaborating rather than building a broken pipe
  generate
    if (PIPE_STAGES < 1 || PIPE_STAGES > MAX_PIPE_STAGES) begin : gBadPipeStages
      $error("greater_than: PIPE_STAGES=%0d outside 1..%0d", PIPE_STAGES, MAX_PIPE_STAGES);
    end
  endgenerate

  operand_t   w_a;
  operand_t   w_b;
  cmp_flags_t w_flags;
  cmp_flags_t w_stageIn;

  cmp_flags_t [PIPE_STAGES-1:0] r_flagPipe;
  logic       [PIPE_STAGES-1:0] r_validPipe;

  assign w_a = {a1, a0};
  assign w_b = {b1, b0};

  greater_than_core u_core (
    .i_a     (w_a),
    .i_b     (w_b),
    .o_flags (w_flags)
  );

  // Invalid slots load zeros so undefined operands never reach the flag registers
  assign w_stageIn = in_valid ? w_flags : '0;

  generate
    if (PIPE_STAGES == 1) begin : gSingleStage
      // Single register stage: sample the compare result directly
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_flagPipe  <= '0;
          r_validPipe <= '0;
        end else begin
          r_flagPipe  <= w_stageIn;
          r_validPipe <= in_valid;
        end
      end
    end else begin : gMultiStage
      // Shift flags and valid together so every slot keeps its qualifier
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_flagPipe  <= '0;
          r_validPipe <= '0;
        end else begin
          r_flagPipe  <= {r_flagPipe[PIPE_STAGES-2:0], w_stageIn};
          r_validPipe <= {r_validPipe[PIPE_STAGES-2:0], in_valid};
        end
      end
    end
  endgenerate

  assign y         = r_flagPipe[PIPE_STAGES-1].gt;
  assign eq        = r_flagPipe[PIPE_STAGES-1].eq;
  assign lt        = r_flagPipe[PIPE_STAGES-1].lt;
  assign out_valid = r_validPipe[PIPE_STAGES-1];

endmodule

// File: tb/tb_greater_than.sv
// tb_greater_than: directed, scoreboard-driven bench for greater_than.
// Every driven cycle pushes the expected {out_valid,y,eq,lt} into a queue;
// the entry at the head is compared once the pipeline delay has elapsed.
// Works in both the unsigned build and with GREATER_THAN_SIGNED_EN defined.
module tb_greater_than;

  localparam int PIPE = 3;

  logic clk = 1'b0;
  logic rstN;
  logic inValid;
  logic a1;
  logic a0;
  logic b1;
  logic b0;
  logic y;
  logic eq;
  logic lt;
  logic outValid;

  int checks = 0;
  int errors = 0;

  logic [3:0] sb[$];

  greater_than #(
    .PIPE_STAGES (PIPE)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .in_valid  (inValid),
    .a1        (a1),
    .a0        (a0),
    .b1        (b1),
    .b0        (b0),
    .y         (y),
    .eq        (eq),
    .lt        (lt),
    .out_valid (outValid)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Reference model built from integer comparison, independent of the RTL equations
  function automatic logic [3:0] model(input logic v, input logic [1:0] a, input logic [1:0] b);
    int ia;
    int ib;
    logic gt;
    logic e;
    logic l;
    if (!v) return 4'b0000;
`ifdef GREATER_THAN_SIGNED_EN
    ia = int'($signed(a));
    ib = int'($signed(b));
`else
    ia = int'(a);
    ib = int'(b);
`endif
    gt = (ia > ib);
    e  = (ia == ib);
    l  = (ia < ib);
    return {1'b1, gt, e, l};
  endfunction

  // Compare the live outputs against one expected {out_valid,y,eq,lt} word
  task automatic checkOutput(input string tag, input logic [3:0] expected);
    logic [3:0] observed;
    observed = {outValid, y, eq, lt};
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed {v,y,eq,lt}=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drive one cycle of operands, record its expectation, and check the result now due
  task automatic applyStimulus(input string tag, input logic v, input logic [1:0] a, input logic [1:0] b);
    inValid  = v;
    {a1, a0} = a;
    {b1, b0} = b;
    sb.push_back(model(v, a, b));
    @(posedge clk);
    #1;
    if (sb.size() >= PIPE) checkOutput(tag, sb.pop_front());
  endtask

  // After a reset the pipeline holds zeros, so the first PIPE-1 results are all-zero
  task automatic restartScoreboard();
    sb.delete();
    repeat (PIPE - 1) sb.push_back(4'b0000);
  endtask

  // Linear directed sequence covering reset, directed pairs, sweep, gaps and mid-stream reset
  initial begin
    logic [3:0] k;
    $display("[TB] greater_than bench, PIPE_STAGES=%0d", PIPE);

    rstN     = 1'b0;
    inValid  = 1'b1;
    {a1, a0} = 2'b10;
    {b1, b0} = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold", 4'b0000);

    #2 rstN = 1'b1;
    restartScoreboard();
    applyStimulus("reset_release", 1'b1, 2'b10, 2'b00);

    applyStimulus("dir_00_00", 1'b1, 2'b00, 2'b00);
    applyStimulus("dir_00_01", 1'b1, 2'b00, 2'b01);
    applyStimulus("dir_00_11", 1'b1, 2'b00, 2'b11);
    applyStimulus("dir_10_00", 1'b1, 2'b10, 2'b00);

    for (int i = 0; i < 16; i++) begin
      k = 4'(i);
      applyStimulus("sweep", 1'b1, k[3:2], k[1:0]);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus("gaps", (i % 2) == 0, 2'b11, 2'b01);
    end

    applyStimulus("x_invalid", 1'b0, 2'bxx, 2'bxx);
    applyStimulus("x_invalid", 1'b0, 2'bx1, 2'b1x);

    applyStimulus("pair_10_00", 1'b1, 2'b10, 2'b00);
    applyStimulus("pair_01_11", 1'b1, 2'b01, 2'b11);
    applyStimulus("pair_11_10", 1'b1, 2'b11, 2'b10);

    repeat (PIPE) applyStimulus("flush", 1'b0, 2'b00, 2'b00);

    applyStimulus("inflight", 1'b1, 2'b11, 2'b01);
    applyStimulus("inflight", 1'b1, 2'b01, 2'b01);
    applyStimulus("inflight", 1'b1, 2'b00, 2'b10);
    #3 rstN = 1'b0;
    #1;
    checkOutput("async_reset_now", 4'b0000);
    inValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("async_reset_held", 4'b0000);
    #2 rstN = 1'b1;
    restartScoreboard();
    repeat (PIPE + 1) applyStimulus("no_stale", 1'b0, 2'b00, 2'b00);

    applyStimulus("recover", 1'b1, 2'b01, 2'b00);
    repeat (PIPE) applyStimulus("recover_flush", 1'b0, 2'b00, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
